// File: rtl/prod_pkg.sv
// prod_pkg: shared types for the lockstep equivalence checker.
//   fail_cause_e : violation cause code reported on fail_cause_o
//   state_e      : checker control state
//   lead_e       : which copy is ahead when observations are buffered
//   pick_cause   : resolves simultaneous violations to one cause code
package prod_pkg;

   localparam int unsigned CAUSE_W = 3;

   typedef enum logic [CAUSE_W-1:0] {
      CAUSE_NONE         = 3'd0,
      CAUSE_OBS_MISMATCH = 3'd1,
      CAUSE_LVL_MISMATCH = 3'd2,
      CAUSE_OVERFLOW     = 3'd3,
      CAUSE_STALL        = 3'd4
   } fail_cause_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FAIL  = 2'd2
   } state_e;

   typedef enum logic {
      LEAD_LEFT  = 1'b0,
      LEAD_RIGHT = 1'b1
   } lead_e;

   // Lower cause code wins when several violations coincide.
   function automatic fail_cause_e pick_cause(input logic obs_mis,
                                              input logic lvl_mis,
                                              input logic ovf,
                                              input logic stall);
      if (obs_mis)    return CAUSE_OBS_MISMATCH;
      else if (lvl_mis) return CAUSE_LVL_MISMATCH;
      else if (ovf)   return CAUSE_OVERFLOW;
      else if (stall) return CAUSE_STALL;
      else            return CAUSE_NONE;
   endfunction

endpackage

// File: rtl/prod_lockstep_equiv_checker_if.sv
// prod_lockstep_equiv_checker_if: observation streams of the two product copies.
//   left/right_valid_i : observation valid per copy
//   left/right_obs_i   : observation word per copy
//   obs_mask_i         : 1 = bit excluded from word compare
//   left/right_lvl_i   : level-signal vectors per copy
// master drives the streams (environment), slave consumes them (checker).
interface prod_lockstep_equiv_checker_if #(
   parameter int unsigned OBS_W = 32,
   parameter int unsigned LVL_W = 166
);
   logic             left_valid_i;
   logic [OBS_W-1:0] left_obs_i;
   logic             right_valid_i;
   logic [OBS_W-1:0] right_obs_i;
   logic [OBS_W-1:0] obs_mask_i;
   logic [LVL_W-1:0] left_lvl_i;
   logic [LVL_W-1:0] right_lvl_i;

   modport master (
      output left_valid_i, left_obs_i, right_valid_i, right_obs_i,
             obs_mask_i, left_lvl_i, right_lvl_i
   );

   modport slave (
      input  left_valid_i, left_obs_i, right_valid_i, right_obs_i,
             obs_mask_i, left_lvl_i, right_lvl_i
   );
endinterface

// File: rtl/prod_obs_fifo.sv
// prod_obs_fifo: synchronous FIFO holding the leading copy's observations.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write data_i (accepted when not full, or full with pop_i)
//   pop_i        : drop head entry (ignored when empty)
//   flush_i      : empty the FIFO
//   data_i       : write data
//   head_o       : oldest entry
//   count_o      : occupancy 0..DEPTH
module prod_obs_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, wr_q;
   logic [PTR_W:0]   cnt_q;
   logic             full, empty, do_push, do_pop;

   assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop_i && !empty;
   // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
   assign do_push = push_i && (!full || do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/prod_lockstep_equiv_checker.sv
// prod_lockstep_equiv_checker: stutter-tolerant equivalence checker for a
// self-composed (Left/Right) product. Word observations are matched in order,
// the leading copy's words are buffered up to DEPTH; level vectors are only
// compared in aligned cycles. The first violation is latched with cause/index.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   en_i           : arm checking; low returns to IDLE
//   obs_if         : Left/Right observation and level streams (slave)
//   equiv_o        : no violation since reset
//   fail_o         : sticky violation flag
//   fail_cause_o   : prod_pkg::fail_cause_e code of the first violation
//   fail_idx_o     : match count when the violation occurred
//   match_cnt_o    : matched observation pairs, saturating
//   lag_o          : buffer occupancy
//   lead_o         : 0 = Left leads, 1 = Right leads (valid when lag_o > 0)
module prod_lockstep_equiv_checker
   import prod_pkg::*;
#(
   parameter int unsigned OBS_W     = 32,
   parameter int unsigned LVL_W     = 166,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned MAX_STALL = 64,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   prod_lockstep_equiv_checker_if.slave obs_if,
   output logic                        equiv_o,
   output logic                        fail_o,
   output logic [2:0]                  fail_cause_o,
   output logic [CNT_W-1:0]            fail_idx_o,
   output logic [CNT_W-1:0]            match_cnt_o,
   output logic [$clog2(DEPTH):0]      lag_o,
   output logic                        lead_o
);
   localparam int unsigned LAG_W   = $clog2(DEPTH) + 1;
   localparam int unsigned STALL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
   localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MAX_STALL);

   state_e             state_q, state_d;
   lead_e              lead_q, lead_d;
   logic [CNT_W-1:0]   match_q, match_d;
   logic [STALL_W-1:0] stall_q, stall_d, stall_inc;
   logic               equiv_q, fail_q;
   fail_cause_e        cause_q, cause_d;
   logic [CNT_W-1:0]   idx_q;

   logic               push, pop, flush;
   logic [OBS_W-1:0]   push_data, head;
   logic [LAG_W-1:0]   lag_cnt;
   logic               lag_full;
   logic [OBS_W-1:0]   cmp_a, cmp_b;
   logic               do_cmp, do_lvl, obs_mis, lvl_mis, ovf, stall_hit, fail_set;
   logic               lead_v, trail_v;
   logic [OBS_W-1:0]   lead_obs, trail_obs;
   logic [LVL_W-1:0]   lvl_diff;

   prod_obs_fifo #(
      .WIDTH (OBS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .data_i  (push_data),
      .head_o  (head),
      .count_o (lag_cnt)
   );

   assign lag_full  = (lag_cnt == LAG_W'(DEPTH));
   assign stall_inc = stall_q + 1'b1;
   assign lvl_diff  = obs_if.left_lvl_i ^ obs_if.right_lvl_i;

   // Buffered words always belong to the leading copy; the trailing copy pops them.
   assign lead_v    = (lead_q == LEAD_LEFT) ? obs_if.left_valid_i  : obs_if.right_valid_i;
   assign lead_obs  = (lead_q == LEAD_LEFT) ? obs_if.left_obs_i    : obs_if.right_obs_i;
   assign trail_v   = (lead_q == LEAD_LEFT) ? obs_if.right_valid_i : obs_if.left_valid_i;
   assign trail_obs = (lead_q == LEAD_LEFT) ? obs_if.right_obs_i   : obs_if.left_obs_i;

   always_comb begin
      state_d   = state_q;
      lead_d    = lead_q;
      match_d   = match_q;
      stall_d   = stall_q;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      push_data = obs_if.left_obs_i;
      cmp_a     = '0;
      cmp_b     = '0;
      do_cmp    = 1'b0;
      do_lvl    = 1'b0;
      ovf       = 1'b0;
      obs_mis   = 1'b0;
      lvl_mis   = 1'b0;
      stall_hit = 1'b0;
      cause_d   = CAUSE_NONE;
      fail_set  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en_i) begin
               state_d = ARMED;
               match_d = '0;
               stall_d = '0;
               flush   = 1'b1;
            end
         end

         ARMED: begin
            if (!en_i) begin
               state_d = IDLE;
               stall_d = '0;
               flush   = 1'b1;
            end else begin
               if (lag_cnt == '0) begin
                  if (obs_if.left_valid_i && obs_if.right_valid_i) begin
                     do_cmp = 1'b1;
                     cmp_a  = obs_if.left_obs_i;
                     cmp_b  = obs_if.right_obs_i;
                     do_lvl = 1'b1;
                  end else if (obs_if.left_valid_i) begin
                     push      = 1'b1;
                     push_data = obs_if.left_obs_i;
                     lead_d    = LEAD_LEFT;
                  end else if (obs_if.right_valid_i) begin
                     push      = 1'b1;
                     push_data = obs_if.right_obs_i;
                     lead_d    = LEAD_RIGHT;
                  end else begin
                     do_lvl = 1'b1;
                  end
               end else begin
                  if (trail_v) begin
                     do_cmp = 1'b1;
                     cmp_a  = head;
                     cmp_b  = trail_obs;
                     pop    = 1'b1;
                  end
                  if (lead_v) begin
                     if (lag_full && !trail_v) begin
                        ovf = 1'b1;
                     end else begin
                        push      = 1'b1;
                        push_data = lead_obs;
                     end
                  end
               end

               obs_mis = do_cmp && (((cmp_a ^ cmp_b) & ~obs_if.obs_mask_i) != '0);
               lvl_mis = do_lvl && (lvl_diff != '0);
               if ((MAX_STALL != 0) && (lag_cnt != '0) && !pop)
                  stall_hit = (stall_inc == STALL_LIM);

               cause_d = pick_cause(obs_mis, lvl_mis, ovf, stall_hit);
               if (cause_d != CAUSE_NONE) begin
                  // Freeze buffer and counters in the violating cycle too.
                  fail_set = 1'b1;
                  state_d  = FAIL;
                  push     = 1'b0;
                  pop      = 1'b0;
                  lead_d   = lead_q;
               end else begin
                  if ((lag_cnt == '0) || pop || (MAX_STALL == 0))
                     stall_d = '0;
                  else
                     stall_d = stall_inc;
                  if (do_cmp && (match_q != '1))
                     match_d = match_q + 1'b1;
               end
            end
         end

         FAIL: begin
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         lead_q  <= LEAD_LEFT;
         match_q <= '0;
         stall_q <= '0;
         equiv_q <= 1'b1;
         fail_q  <= 1'b0;
         cause_q <= CAUSE_NONE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         lead_q  <= lead_d;
         match_q <= match_d;
         stall_q <= stall_d;
         if (fail_set) begin
            equiv_q <= 1'b0;
            fail_q  <= 1'b1;
            cause_q <= cause_d;
            idx_q   <= match_q;
         end
      end
   end

   assign equiv_o      = equiv_q;
   assign fail_o       = fail_q;
   assign fail_cause_o = cause_q;
   assign fail_idx_o   = idx_q;
   assign match_cnt_o  = match_q;
   assign lag_o        = lag_cnt;
   assign lead_o       = lead_q;
endmodule

// File: tb/tb_prod_lockstep_equiv_checker.sv
module tb_prod_lockstep_equiv_checker;
   localparam int unsigned OBS_W = 32;
   localparam int unsigned LVL_W = 166;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAX_STALL = 8;
   localparam int unsigned CNT_W = 32;

   logic             clk;
   logic             rst;
   logic             en;
   logic             equiv, fail;
   logic [2:0]       cause;
   logic [CNT_W-1:0] idx, match;
   logic [2:0]       lag;
   logic             lead;

   int total = 0;
   int bad   = 0;

   prod_lockstep_equiv_checker_if #(.OBS_W(OBS_W), .LVL_W(LVL_W)) bus ();

   prod_lockstep_equiv_checker #(
      .OBS_W     (OBS_W),
      .LVL_W     (LVL_W),
      .DEPTH     (DEPTH),
      .MAX_STALL (MAX_STALL),
      .CNT_W     (CNT_W)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .obs_if       (bus),
      .equiv_o      (equiv),
      .fail_o       (fail),
      .fail_cause_o (cause),
      .fail_idx_o   (idx),
      .match_cnt_o  (match),
      .lag_o        (lag),
      .lead_o       (lead)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".equiv"}, 64'(equiv), 64'd1);
      chk({tag, ".fail"},  64'(fail),  64'd0);
      chk({tag, ".cause"}, 64'(cause), 64'd0);
      chk({tag, ".idx"},   64'(idx),   64'd0);
      chk({tag, ".match"}, 64'(match), 64'd0);
      chk({tag, ".lag"},   64'(lag),   64'd0);
      chk({tag, ".lead"},  64'(lead),  64'd0);
   endtask

   task automatic quiet();
      bus.left_valid_i  = 1'b0;
      bus.right_valid_i = 1'b0;
      bus.obs_mask_i    = '0;
      bus.right_lvl_i   = bus.left_lvl_i;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      quiet();
      tick();
      rst = 1'b0;
   endtask

   task automatic arm();
      en = 1'b1;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      bus.left_obs_i  = '0;
      bus.right_obs_i = '0;
      bus.left_lvl_i  = 166'h3F_1234_5678_9ABC_DEF0_1357;
      quiet();
      tick();
      tick();
      chk_reset("reset");
      rst = 1'b0;

      // Aligned stream
      arm();
      chk("arm.match", 64'(match), 64'd0);
      bus.left_valid_i  = 1'b1;
      bus.right_valid_i = 1'b1;
      bus.left_obs_i    = 32'hDEADBEEF;
      bus.right_obs_i   = 32'hDEADBEEF;
      repeat (5) tick();
      chk("aligned.match", 64'(match), 64'd5);
      chk("aligned.lag",   64'(lag),   64'd0);
      chk("aligned.equiv", 64'(equiv), 64'd1);

      // Stutter: Left leads by up to three, level mismatch while lagging ignored
      bus.right_valid_i = 1'b0;
      bus.left_obs_i = 32'hA;
      tick();
      chk("stutter.lag0",  64'(lag),  64'd1);
      chk("stutter.lead",  64'(lead), 64'd0);
      bus.left_obs_i = 32'hB;
      tick();
      chk("stutter.lag1", 64'(lag), 64'd2);
      bus.left_obs_i = 32'hC;
      bus.right_lvl_i[0] = ~bus.left_lvl_i[0];
      tick();
      chk("stutter.lag2", 64'(lag), 64'd3);
      bus.right_lvl_i   = bus.left_lvl_i;
      bus.left_valid_i  = 1'b0;
      bus.right_valid_i = 1'b1;
      bus.right_obs_i   = 32'hA;
      tick();
      chk("stutter.lag3", 64'(lag), 64'd2);
      bus.right_obs_i = 32'hB;
      tick();
      chk("stutter.lag4", 64'(lag), 64'd1);
      bus.right_obs_i = 32'hC;
      tick();
      chk("stutter.lag5",  64'(lag),   64'd0);
      chk("stutter.match", 64'(match), 64'd8);
      chk("stutter.equiv", 64'(equiv), 64'd1);
      chk("stutter.fail",  64'(fail),  64'd0);
      bus.right_valid_i = 1'b0;

      // Disarm holds the count, re-arm clears it
      en = 1'b0;
      tick();
      chk("disarm.match", 64'(match), 64'd8);
      arm();
      chk("rearm.match", 64'(match), 64'd0);

      // Masked mismatch passes, unmasked one fails with index 7
      bus.left_valid_i  = 1'b1;
      bus.right_valid_i = 1'b1;
      bus.left_obs_i    = 32'h12345678;
      bus.right_obs_i   = 32'h12345678;
      repeat (6) tick();
      chk("mask.pre_match", 64'(match), 64'd6);
      bus.left_obs_i  = 32'h1;
      bus.right_obs_i = 32'h0;
      bus.obs_mask_i  = 32'h1;
      tick();
      chk("mask.pass_match", 64'(match), 64'd7);
      chk("mask.pass_fail",  64'(fail),  64'd0);
      bus.obs_mask_i = 32'h0;
      tick();
      chk("obsmis.fail",  64'(fail),  64'd1);
      chk("obsmis.cause", 64'(cause), 64'd1);
      chk("obsmis.idx",   64'(idx),   64'd7);
      chk("obsmis.equiv", 64'(equiv), 64'd0);
      chk("obsmis.match", 64'(match), 64'd7);
      bus.left_obs_i  = 32'h5;
      bus.right_obs_i = 32'h5;
      en = 1'b0;
      tick();
      chk("frozen.match", 64'(match), 64'd7);
      chk("frozen.cause", 64'(cause), 64'd1);
      chk("frozen.fail",  64'(fail),  64'd1);

      // Reset while in FAIL
      do_reset();
      chk_reset("rst_fail");

      // en_i low mid-lag
      arm();
      bus.left_valid_i  = 1'b1;
      bus.right_valid_i = 1'b1;
      bus.left_obs_i    = 32'h77;
      bus.right_obs_i   = 32'h77;
      tick();
      tick();
      chk("midlag.match", 64'(match), 64'd2);
      bus.right_valid_i = 1'b0;
      tick();
      tick();
      chk("midlag.lag", 64'(lag), 64'd2);
      bus.left_valid_i = 1'b0;
      en = 1'b0;
      tick();
      chk("midlag.off_lag",   64'(lag),   64'd0);
      chk("midlag.off_match", 64'(match), 64'd2);
      arm();
      chk("midlag.rearm_match", 64'(match), 64'd0);
      chk("midlag.rearm_lag",   64'(lag),   64'd0);

      // Overflow: five Left words with Right idle
      bus.left_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.left_obs_i = 32'h10 + 32'(i);
         tick();
      end
      chk("ovf.pre_lag",  64'(lag),  64'd4);
      chk("ovf.pre_fail", 64'(fail), 64'd0);
      bus.left_obs_i = 32'h14;
      tick();
      chk("ovf.fail",  64'(fail),  64'd1);
      chk("ovf.cause", 64'(cause), 64'd3);
      chk("ovf.lag",   64'(lag),   64'd4);
      chk("ovf.idx",   64'(idx),   64'd0);

      // Full buffer: push+pop is legal, then mismatch beats overflow
      do_reset();
      arm();
      bus.left_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.left_obs_i = 32'h20 + 32'(i);
         tick();
      end
      bus.left_obs_i    = 32'h24;
      bus.right_valid_i = 1'b1;
      bus.right_obs_i   = 32'h20;
      tick();
      chk("full.pp_lag",   64'(lag),   64'd4);
      chk("full.pp_match", 64'(match), 64'd1);
      chk("full.pp_fail",  64'(fail),  64'd0);
      bus.left_obs_i  = 32'h25;
      bus.right_obs_i = 32'h99;
      tick();
      chk("full.mis_cause", 64'(cause), 64'd1);
      chk("full.mis_idx",   64'(idx),   64'd1);
      chk("full.mis_lag",   64'(lag),   64'd4);

      // Stall: one Left word, Right silent
      do_reset();
      arm();
      bus.left_valid_i = 1'b1;
      bus.left_obs_i   = 32'h42;
      tick();
      bus.left_valid_i = 1'b0;
      repeat (7) tick();
      chk("stall.pre_fail", 64'(fail), 64'd0);
      chk("stall.pre_lag",  64'(lag),  64'd1);
      tick();
      chk("stall.fail",  64'(fail),  64'd1);
      chk("stall.cause", 64'(cause), 64'd4);
      chk("stall.idx",   64'(idx),   64'd0);

      // Level mismatch on bit 165 in an aligned cycle
      do_reset();
      arm();
      bus.left_valid_i  = 1'b1;
      bus.right_valid_i = 1'b1;
      bus.left_obs_i    = 32'h5A5A;
      bus.right_obs_i   = 32'h5A5A;
      tick();
      chk("lvl.pre_match", 64'(match), 64'd1);
      bus.right_lvl_i[165] = ~bus.left_lvl_i[165];
      tick();
      chk("lvl.cause", 64'(cause), 64'd2);
      chk("lvl.idx",   64'(idx),   64'd1);
      chk("lvl.equiv", 64'(equiv), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
